// File: rtl/matrix_stream_generator.sv
// Streams REPEAT frames of constant-valued DIM x DIM matrices (A then B) over
// AXI-Stream to a matrix multiplier, after a programmable start delay.
module matrix_stream_generator #(
    parameter int unsigned DIM               = 6,
    parameter int unsigned REPEAT            = 6,
    parameter logic [31:0] A_VALUE           = 32'd2,
    parameter logic [31:0] B_VALUE           = 32'd1,
    parameter logic [19:0] Start_Delay_Value = 20'd20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        input_r_TREADY_0,
    output logic        input_r_TVALID_0,
    output logic [31:0] input_r_TDATA_0,
    output logic        input_r_TLAST_0,
    output logic        busy,
    output logic        done,
    output logic [7:0]  Frame_Counter
);

    // state  | meaning
    // IDLE   | waiting for start; Frame_Counter holds the last run's count
    // WAIT   | start delay down-counter running
    // SEND_A | streaming matrix A words
    // SEND_B | streaming matrix B words
    // DONE   | one-cycle done pulse, then back to IDLE

    localparam int unsigned    WORDS     = DIM * DIM;
    localparam int unsigned    CW        = $clog2(WORDS);
    localparam logic [CW-1:0]  LAST_BEAT = CW'(WORDS - 1);
    localparam logic [CW-1:0]  PRE_LAST  = CW'(WORDS - 2);
    localparam logic [CW-1:0]  BEAT_ONE  = CW'(1);
    localparam logic [7:0]     REPEAT_W  = 8'(REPEAT);

    typedef enum logic [2:0] {IDLE, WAIT, SEND_A, SEND_B, DONE} state_t;

    state_t        state;
    logic [CW-1:0] beat_cnt;
    logic [19:0]   delay_cnt;
    logic [7:0]    frame_next;

    assign frame_next = Frame_Counter + 8'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            beat_cnt         <= '0;
            delay_cnt        <= '0;
            input_r_TVALID_0 <= 1'b0;
            input_r_TDATA_0  <= '0;
            input_r_TLAST_0  <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            Frame_Counter    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state         <= WAIT;
                        delay_cnt     <= Start_Delay_Value;
                        Frame_Counter <= '0;
                        busy          <= 1'b1;
                    end
                end
                WAIT: begin
                    if (delay_cnt == 20'd0) begin
                        state            <= SEND_A;
                        beat_cnt         <= '0;
                        input_r_TVALID_0 <= 1'b1;
                        input_r_TDATA_0  <= A_VALUE;
                        input_r_TLAST_0  <= 1'b0;
                    end else begin
                        delay_cnt <= delay_cnt - 20'd1;
                    end
                end
                SEND_A: begin
                    if (input_r_TREADY_0) begin
                        if (beat_cnt == LAST_BEAT) begin
                            state           <= SEND_B;
                            beat_cnt        <= '0;
                            input_r_TDATA_0 <= B_VALUE;
                            input_r_TLAST_0 <= 1'b0;
                        end else begin
                            beat_cnt        <= beat_cnt + BEAT_ONE;
                            input_r_TLAST_0 <= (beat_cnt == PRE_LAST);
                        end
                    end
                end
                SEND_B: begin
                    if (input_r_TREADY_0) begin
                        if (beat_cnt == LAST_BEAT) begin
                            beat_cnt        <= '0;
                            Frame_Counter   <= frame_next;
                            input_r_TLAST_0 <= 1'b0;
                            // Next frame follows back-to-back; only the final frame drops valid.
                            if (frame_next < REPEAT_W) begin
                                state           <= SEND_A;
                                input_r_TDATA_0 <= A_VALUE;
                            end else begin
                                state            <= DONE;
                                input_r_TVALID_0 <= 1'b0;
                                input_r_TDATA_0  <= '0;
                                done             <= 1'b1;
                            end
                        end else begin
                            beat_cnt        <= beat_cnt + BEAT_ONE;
                            input_r_TLAST_0 <= (beat_cnt == PRE_LAST);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state            <= IDLE;
                    beat_cnt         <= '0;
                    input_r_TVALID_0 <= 1'b0;
                    input_r_TDATA_0  <= '0;
                    input_r_TLAST_0  <= 1'b0;
                    busy             <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_stream_generator.sv
// Bench for matrix_stream_generator: default-parameter runs under several
// TREADY patterns plus a small DIM=2 instance, checked against a beat model.
module tb_matrix_stream_generator;

    localparam int N     = 36;
    localparam int REP   = 6;
    localparam int TOTAL = 2 * N * REP;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, tready;
    logic        valid, last, busy, done;
    logic [31:0] data;
    logic [7:0]  fc;
    logic        start_s, tready_s;
    logic        valid_s, last_s, busy_s, done_s;
    logic [31:0] data_s;
    logic [7:0]  fc_s;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    matrix_stream_generator dut (
        .clk(clk), .reset(rst_n), .start(start),
        .input_r_TREADY_0(tready), .input_r_TVALID_0(valid),
        .input_r_TDATA_0(data), .input_r_TLAST_0(last),
        .busy(busy), .done(done), .Frame_Counter(fc)
    );

    matrix_stream_generator #(.DIM(2), .REPEAT(1), .Start_Delay_Value(20'd0)) dut_s (
        .clk(clk), .reset(rst_n), .start(start_s),
        .input_r_TREADY_0(tready_s), .input_r_TVALID_0(valid_s),
        .input_r_TDATA_0(data_s), .input_r_TLAST_0(last_s),
        .busy(busy_s), .done(done_s), .Frame_Counter(fc_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Word k of a run belongs to matrix k/n; even matrices are A, odd are B.
    function automatic logic [31:0] exp_data(input int k, input int n);
        return ((k / n) % 2 == 0) ? 32'd2 : 32'd1;
    endfunction

    function automatic logic exp_last(input int k, input int n);
        return (k % n) == (n - 1);
    endfunction

    // mode 1: ready=1, 2: toggling, 3: random, 4: 1000-cycle stall then random
    task automatic run_main(input int mode, input bit poke_start, input int reset_at);
        int          k = 0;
        int          dones = 0;
        int          cyc;
        int          first = -1;
        bit          have_hold = 0;
        bit          poked = 0;
        bit          rdy;
        logic [31:0] hold_d = '0;
        logic        hold_l = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (cyc = 1; cyc < 4000; cyc++) begin
            if (first < 0 && valid === 1'b1) begin
                first = cyc;
                chk("first_valid_latency", 32'(cyc - 1), 32'd21);
            end
            if (first >= 0) chk("valid_contiguous", 32'(valid), 32'(k < TOTAL));
            if (valid === 1'b1) begin
                chk("tdata", data, exp_data(k, N));
                chk("tlast", 32'(last), 32'(exp_last(k, N)));
            end else begin
                chk("tdata_idle_zero", data, 32'd0);
            end
            if (have_hold) begin
                chk("stall_tdata_stable", data, hold_d);
                chk("stall_tlast_stable", 32'(last), 32'(hold_l));
            end
            if (done === 1'b1) begin
                dones++;
                chk("done_after_last", 32'(k), 32'(TOTAL));
                chk("frame_count_at_done", 32'(fc), 32'(REP));
                break;
            end
            if (reset_at > 0 && k == reset_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_tvalid", 32'(valid), 32'd0);
                chk("rst_tdata", data, 32'd0);
                chk("rst_tlast", 32'(last), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_done", 32'(done), 32'd0);
                chk("rst_frames", 32'(fc), 32'd0);
                @(negedge clk);
                chk("rst_held_tvalid", 32'(valid), 32'd0);
                rst_n = 1'b1;
                return;
            end
            case (mode)
                1:       rdy = 1'b1;
                2:       rdy = (cyc % 2 == 0);
                4:       rdy = (first >= 0 && cyc - first < 1000) ? 1'b0 : 1'($urandom_range(0, 1));
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            if (poke_start && !poked && valid === 1'b1 && (k / N) % 2 == 1 && k % N == 10) begin
                start = 1'b1;
                poked = 1'b1;
            end else begin
                start = 1'b0;
            end
            have_hold = (valid === 1'b1) && !rdy;
            hold_d = data;
            hold_l = last;
            if (valid === 1'b1 && rdy) k++;
            tready = rdy;
            @(negedge clk);
        end
        start = 1'b0;
        chk("transfers_per_run", 32'(k), 32'(TOTAL));
        chk("done_pulses", 32'(dones), 32'd1);
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_frames_held", 32'(fc), 32'(REP));
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            chk("no_restart", 32'(valid | busy), 32'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; tready = 1'b0; start_s = 1'b0; tready_s = 1'b1;
        #2;
        chk("reset_tvalid", 32'(valid), 32'd0);
        chk("reset_tdata", data, 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_frames", 32'(fc), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Small instance: 1-cycle WAIT, 2,2,2,2 then 1,1,1,1, done, one frame.
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        for (int i = 1; i <= 11; i++) begin
            automatic int j  = i - 2;
            automatic bit ev = (j >= 0 && j < 8);
            chk("s_tvalid", 32'(valid_s), 32'(ev));
            chk("s_tdata", data_s, ev ? exp_data(j, 4) : 32'd0);
            chk("s_tlast", 32'(last_s), 32'(ev && exp_last(j, 4)));
            chk("s_done", 32'(done_s), 32'(i == 10));
            chk("s_busy", 32'(busy_s), 32'(i <= 10));
            @(negedge clk);
        end
        chk("s_frames", 32'(fc_s), 32'd1);

        run_main(1, 1'b0, 0);
        run_main(2, 1'b0, 0);
        run_main(3, 1'b0, 0);
        run_main(4, 1'b0, 0);
        run_main(1, 1'b1, 0);
        run_main(3, 1'b0, 50);
        run_main(1, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
